sample_loader: RTL and testbench
================================

SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 Parameter BASE_ADDR, default 21'h000000: EBI address of word slot 0; block decodes BASE_ADDR..BASE_ADDR+18.
REQ-002 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port reset  input  1  asynchronous reset, active-high.
REQ-004 Port ebi_data  input  16  EBI write data.
REQ-005 Port ebi_addr  input  21  EBI address.
REQ-006 Port ebi_wr  input  1  EBI write strobe, active-high.
REQ-007 Port ebi_rd  input  1  EBI read strobe, active-high.
REQ-008 Port ebi_cs  input  1  EBI chip select, active-high.
REQ-009 Port rd_data  output  16  registered EBI read data.
REQ-010 Port data_out  output  256  committed sample toward the PWM stage.
REQ-011 Port data_valid  output  1  data_out holds an unconsumed sample.
REQ-012 Port data_ready  input  1  PWM stage accepts data_out.

Function
REQ-013 The block SHALL treat wr_evt = ebi_cs & ebi_wr & !(previous-cycle ebi_cs & ebi_wr) as exactly one write, regardless of how long the strobe is held.
REQ-014 Offsets are relative to BASE_ADDR. A write to offset k (0..15) SHALL load staging[16k+15:16k] and set word_mask[k].
REQ-015 A write to offset 16 (CTRL) SHALL act on bit0 = commit and bit1 = clear overflow; both may be set together, and both take effect.
REQ-016 Writes to offsets 17..18, or outside 0..18, SHALL be ignored.
REQ-017 When ebi_cs & ebi_rd is high, the block SHALL register rd_data on the next edge. Offset 17 gives {12'b0, ovf, pend, data_valid, full}, with full = (word_mask == 16'hFFFF). Offset 18 gives word_mask. Offsets 0..15 give the staging word. Any other offset gives 16'h0000.
REQ-018 When ebi_cs & ebi_rd is low, rd_data SHALL hold its previous value.
REQ-019 The FSM SHALL have three states: IDLE (data_valid=0), HOLD (data_valid=1, pend=0) and HOLD_PEND (data_valid=1, pend=1).
REQ-020 IDLE + commit: copy staging to data_out, clear word_mask, go to HOLD. data_valid rises on the edge after the write cycle, giving 1-cycle latency.
REQ-021 HOLD + data_ready with no commit: go to IDLE.
REQ-022 HOLD + commit with data_ready in the same cycle: copy staging to data_out, clear word_mask, stay in HOLD. No bubble is allowed.
REQ-023 HOLD + commit without data_ready: go to HOLD_PEND. Staging and word_mask remain EBI-writable.
REQ-024 HOLD_PEND + data_ready: copy the current staging contents to data_out, clear word_mask, go to HOLD.
REQ-025 HOLD_PEND + commit: set ovf (sticky) and stay in HOLD_PEND. If data_ready is asserted in the same cycle, REQ-024 also applies.
REQ-026 data_out SHALL change only on a copy event and SHALL stay stable while data_valid=1 and data_ready=0.
REQ-027 A slot write and a copy in the same cycle SHALL copy the pre-write staging. The mask bit for the written slot then ends set, because the write wins over the clear.
REQ-028 data_ready while in IDLE SHALL be ignored.
REQ-029 Clearing ovf in the same cycle as an event that would set it SHALL leave ovf=1, because set wins.
REQ-030 Commit with a partially filled word_mask SHALL still commit. Unwritten slots keep their previous staging values.

Reset
REQ-031 While reset is high, the block SHALL force state=IDLE, data_out=0, staging=0, word_mask=0, ovf=0, rd_data=0, data_valid=0 and the wr_evt history flop=0.
REQ-032 Reset asserted mid-operation, including in HOLD_PEND, SHALL discard all pending data immediately, without waiting for a clock edge.
REQ-033 After reset deasserts, a strobe that is already held high SHALL count as a new write on the first edge.

Verification
REQ-034 Scenario 1: write 16'h000F to offset 0, then 16'h0001 to CTRL -> data_valid=1 one cycle later, data_out=256'h...000F, mask reads 0.
REQ-035 Scenario 2: hold ebi_cs=ebi_wr=1 for 5 cycles at offset 3 with data 16'hABCD -> exactly one write, word_mask=16'h0008.
REQ-036 Scenario 3: commit A with data_ready=0, write 16'h1234 to offset 1, commit again -> pend=1. Then raise data_ready -> data_out[31:16]=16'h1234, state HOLD.
REQ-037 Scenario 4: in HOLD_PEND, a third commit -> status bit3 (ovf)=1. Write 16'h0002 to CTRL -> ovf=0.
REQ-038 Scenario 5: fill all 16 words -> status reads 16'h0001 (full). Read offset 7 -> rd_data returns the written word one cycle later.
REQ-039 Scenario 6: assert reset asynchronously while data_valid=1 -> data_valid=0 and data_out=0 before the next clock edge.

Source files
------------

// File: rtl/sample_loader.sv
// sample_loader: EBI-loaded 16x16-bit staging buffer handed to the PWM stage as one 256-bit sample (clk/reset, ebi_* bus in, rd_data out, data_out/data_valid out with data_ready handshake in)
module sample_loader #(
  parameter logic [20:0] BASE_ADDR = 21'h000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  ebi_data,
  input  logic [20:0]  ebi_addr,
  input  logic         ebi_wr,
  input  logic         ebi_rd,
  input  logic         ebi_cs,
  output logic [15:0]  rd_data,
  output logic [255:0] data_out,
  output logic         data_valid,
  input  logic         data_ready
);
  typedef enum logic [1:0] {IDLE, HOLD, HOLD_PEND} state_t;
  state_t state, state_n;
  logic [255:0] staging;
  logic [15:0]  word_mask, rd_n;
  logic [20:0]  off;
  logic         ovf, wr_q, wr_evt, slot_wr, ctrl_wr, commit, clr_ovf, copy, set_ovf, pend, full;
  assign off        = ebi_addr - BASE_ADDR;
  assign wr_evt     = ebi_cs & ebi_wr & ~wr_q;
  assign slot_wr    = wr_evt & (off < 21'd16);
  assign ctrl_wr    = wr_evt & (off == 21'd16);
  assign commit     = ctrl_wr & ebi_data[0];
  assign clr_ovf    = ctrl_wr & ebi_data[1];
  assign pend       = state == HOLD_PEND;
  assign data_valid = state != IDLE;
  assign full       = &word_mask;
  assign rd_n = off < 21'd16  ? staging[{off[3:0], 4'b0} +: 16] :
                off == 21'd17 ? {12'b0, ovf, pend, data_valid, full} :
                off == 21'd18 ? word_mask : 16'h0000;
  always_comb begin
    state_n = state;
    copy    = 1'b0;
    set_ovf = 1'b0;
    case (state)
      IDLE: begin
        copy    = commit;
        state_n = commit ? HOLD : IDLE;
      end
      HOLD: begin
        copy    = commit & data_ready;
        state_n = commit ? (data_ready ? HOLD : HOLD_PEND) : (data_ready ? IDLE : HOLD);
      end
      default: begin
        set_ovf = commit;
        copy    = data_ready;
        state_n = data_ready ? HOLD : HOLD_PEND;
      end
    endcase
  end
  // Copy samples the registered staging, so a same-cycle slot write lands only in staging
  // and its mask bit survives the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      data_out  <= '0;
      staging   <= '0;
      word_mask <= '0;
      ovf       <= 1'b0;
      rd_data   <= '0;
      wr_q      <= 1'b0;
    end else begin
      state     <= state_n;
      wr_q      <= ebi_cs & ebi_wr;
      if (copy) data_out <= staging;
      if (slot_wr) staging[{off[3:0], 4'b0} +: 16] <= ebi_data;
      word_mask <= (copy ? 16'h0000 : word_mask) | (slot_wr ? 16'h0001 << off[3:0] : 16'h0000);
      ovf       <= set_ovf | (ovf & ~clr_ovf);
      if (ebi_cs & ebi_rd) rd_data <= rd_n;
    end
  end
endmodule

// File: tb/tb_sample_loader.sv
// tb_sample_loader: scoreboard bench for sample_loader (read-back queue and committed-sample queue)
module tb_sample_loader;
  localparam logic [20:0] BASE = 21'h001000;
  logic         clk = 1'b0, reset = 1'b1;
  logic [15:0]  ebi_data = '0;
  logic [20:0]  ebi_addr = '0;
  logic         ebi_wr = 1'b0, ebi_rd = 1'b0, ebi_cs = 1'b0, data_ready = 1'b0;
  logic [15:0]  rd_data;
  logic [255:0] data_out;
  logic         data_valid;
  logic [255:0] m_stage = '0;
  logic [255:0] dq[$];
  logic [15:0]  rq[$];
  int total = 0, bad = 0;
  sample_loader #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .ebi_data(ebi_data), .ebi_addr(ebi_addr), .ebi_wr(ebi_wr),
    .ebi_rd(ebi_rd), .ebi_cs(ebi_cs), .rd_data(rd_data), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask
  task automatic wr(input int off, input logic [15:0] d, input logic rdy = 1'b0);
    @(posedge clk); #1;
    ebi_addr = BASE + 21'(off); ebi_data = d; ebi_cs = 1'b1; ebi_wr = 1'b1; data_ready = rdy;
    @(posedge clk); #1;
    ebi_cs = 1'b0; ebi_wr = 1'b0; data_ready = 1'b0;
    if (off < 16) m_stage[off*16 +: 16] = d;
  endtask
  task automatic rd(input string tag, input int off, input logic [15:0] e);
    @(posedge clk); #1;
    ebi_addr = BASE + 21'(off); ebi_cs = 1'b1; ebi_rd = 1'b1;
    rq.push_back(e);
    @(posedge clk); #1;
    ebi_cs = 1'b0; ebi_rd = 1'b0;
    check(tag, 256'(rd_data), 256'(rq.pop_front()));
  endtask
  task automatic take();
    @(posedge clk); #1;
    data_ready = 1'b1;
    @(posedge clk); #1;
    data_ready = 1'b0;
  endtask
  always @(negedge clk)
    if (!reset && data_valid && data_ready) begin
      if (dq.size() == 0) check("dout_extra", 256'(1), 256'(0));
      else check("dout", data_out, dq.pop_front());
    end
  logic [255:0] a_smp;
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 256'(data_valid), 256'(0));
    check("rst_dout", data_out, '0);
    check("rst_rd", 256'(rd_data), 256'(0));
    reset = 1'b0;
    wr(0, 16'h000F);
    dq.push_back(m_stage);
    wr(16, 16'h0001);
    check("s1_valid", 256'(data_valid), 256'(1));
    check("s1_dout", data_out, 256'h000F);
    rd("s1_mask", 18, 16'h0000);
    rd("s1_stat", 17, 16'h0002);
    take();
    check("s1_idle", 256'(data_valid), 256'(0));
    @(posedge clk); #1;
    ebi_addr = BASE + 21'd3; ebi_data = 16'hABCD; ebi_cs = 1'b1; ebi_wr = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    ebi_cs = 1'b0; ebi_wr = 1'b0;
    m_stage[63:48] = 16'hABCD;
    rd("s2_mask", 18, 16'h0008);
    rd("s2_word", 3, 16'hABCD);
    take();
    check("idle_ready", 256'(data_valid), 256'(0));
    rd("idle_stat", 17, 16'h0000);
    a_smp = m_stage;
    dq.push_back(m_stage);
    wr(16, 16'h0001);
    wr(1, 16'h1234);
    wr(16, 16'h0001);
    rd("s3_stat", 17, 16'h0006);
    rd("s3_mask", 18, 16'h0002);
    check("s3_stable", data_out, a_smp);
    dq.push_back(m_stage);
    take();
    check("s3_word1", 256'(data_out[31:16]), 256'h1234);
    rd("s3_hold", 17, 16'h0002);
    rd("s3_mask0", 18, 16'h0000);
    take();
    dq.push_back(m_stage);
    wr(16, 16'h0001);
    wr(16, 16'h0001);
    wr(16, 16'h0001);
    rd("s4_ovf", 17, 16'h000E);
    wr(16, 16'h0002);
    rd("s4_clr", 17, 16'h0006);
    wr(16, 16'h0003);
    rd("s4_setwin", 17, 16'h000E);
    wr(16, 16'h0002);
    rd("s4_clr2", 17, 16'h0006);
    dq.push_back(m_stage);
    take();
    wr(2, 16'h2222);
    dq.push_back(m_stage);
    wr(16, 16'h0001, 1'b1);
    check("nobubble_valid", 256'(data_valid), 256'(1));
    check("nobubble_dout", data_out, m_stage);
    wr(16, 16'h0001);
    dq.push_back(m_stage);
    wr(4, 16'h4444, 1'b1);
    rd("wrcopy_mask", 18, 16'h0010);
    rd("wrcopy_word", 4, 16'h4444);
    rd("wrcopy_stat", 17, 16'h0002);
    take();
    for (int i = 0; i < 16; i++) wr(i, 16'h1000 + 16'(i));
    rd("s5_full", 17, 16'h0001);
    rd("s5_w7", 7, 16'h1007);
    rd("s5_mask", 18, 16'hFFFF);
    wr(17, 16'hFFFF);
    wr(18, 16'h0000);
    wr(20, 16'h0001);
    rd("ign_mask", 18, 16'hFFFF);
    rd("ign_stat", 17, 16'h0001);
    rd("oor_hi", 19, 16'h0000);
    rd("oor_lo", -1, 16'h0000);
    dq.push_back(m_stage);
    wr(16, 16'h0001);
    check("s6_valid", 256'(data_valid), 256'(1));
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("s6_async_valid", 256'(data_valid), 256'(0));
    check("s6_async_dout", data_out, '0);
    dq.delete();
    m_stage = '0;
    ebi_addr = BASE + 21'd5; ebi_data = 16'h5555; ebi_cs = 1'b1; ebi_wr = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ebi_cs = 1'b0; ebi_wr = 1'b0;
    rd("held_mask", 18, 16'h0020);
    rd("held_word", 5, 16'h5555);
    rd("rst_stage", 0, 16'h0000);
    check("dq_empty", 256'(dq.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
